inst_fetch_controller: RTL and testbench

Fetch sequencer that owns the program counter and drives the combinational byte-addressed instruction memory. It assembles each fetched 32-bit word into a small in-order buffer, tagged with the word's PC. The buffer presents to decode over a valid/ready handshake. Branch/jump redirects flush the buffer and retarget fetch; an optional range check halts fetch on out-of-bounds PCs.

---
 rtl/inst_fetch_controller_if.sv | 40 ++++
 rtl/inst_fetch_controller.sv | 188 ++++++++++++++++++
 tb/tb_inst_fetch_controller.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_controller_if.sv
// ---------------------------------------------------------------------------
// inst_fetch_controller_if
//
// Purpose: bundles the instruction-memory bus, the redirect request and the
// decode-side valid/ready handshake of the fetch controller.
//
// Signals:
//   Inst_Address   [63:0]  byte address to instruction memory (controller drives)
//   Instruction    [31:0]  combinational memory read data, little-endian
//   redirect_valid         one-cycle fetch retarget request
//   redirect_pc    [63:0]  retarget PC, bits [1:0] ignored
//   inst_valid             buffer head valid (controller drives)
//   inst_ready             decode accepts head this cycle
//   inst_out       [31:0]  head instruction, 0 when not valid
//   inst_pc        [63:0]  head PC, 0 when not valid
//   fault                  fetch halted on an out-of-range PC
//
// Modports: master = fetch controller, slave = memory/decode/branch side.
// ---------------------------------------------------------------------------
interface inst_fetch_controller_if;
    logic [63:0] Inst_Address;
    logic [31:0] Instruction;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [63:0] inst_pc;
    logic        fault;

    modport master (
        output Inst_Address, inst_valid, inst_out, inst_pc, fault,
        input  Instruction, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  Inst_Address, inst_valid, inst_out, inst_pc, fault,
        output Instruction, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/inst_fetch_controller.sv
// ---------------------------------------------------------------------------
// inst_fetch_controller
//
// Purpose: owns the program counter, fetches 32-bit words from a
// combinational instruction memory and queues them, tagged with their PC,
// in a small in-order buffer presented to decode over valid/ready.
// Redirects flush the buffer and retarget fetch.
//
// Parameters:
//   MEM_BYTES  instruction memory size in bytes (power of two, multiple of 4)
//   RESET_PC   PC loaded on reset (4-byte aligned)
//   DEPTH      buffer entries, 2..4
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    inst_fetch_controller_if.master (memory, redirect, decode handshake)
//
// Build option:
//   IFETCH_BOUND_CHECK_EN  when defined, a PC above MEM_BYTES-4 halts fetch
//                          (FAULT state, fault=1) until a redirect. When not
//                          defined, the memory address wraps within MEM_BYTES
//                          and fault is tied low.
// ---------------------------------------------------------------------------
module inst_fetch_controller #(
    parameter int unsigned MEM_BYTES = 16,
    parameter logic [63:0] RESET_PC  = 64'd0,
    parameter int unsigned DEPTH     = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    inst_fetch_controller_if.master       bus
);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    localparam logic [2:0] DEPTH_C = 3'(DEPTH);
`ifdef IFETCH_BOUND_CHECK_EN
    localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 4);
`else
    localparam logic [63:0] ADDR_MASK = 64'(MEM_BYTES - 1);
`endif

    // Storage is sized for the largest DEPTH so a 2-bit pointer indexes it
    // exactly; only entries 0..DEPTH-1 are ever used.
    logic [63:0] ent_pc_q  [4];
    logic [31:0] ent_ins_q [4];

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [2:0]  count_q, count_d;
    logic [1:0]  head_q, head_d;

    logic        valid_s;
    logic        pop_s;
    logic        push_s;
    logic        flush_s;
    logic        out_of_range_s;
    logic [1:0]  tail_s;
    logic [63:0] redirect_tgt_s;

    // Circular pointer addition modulo DEPTH (base < DEPTH, off <= DEPTH).
    function automatic logic [1:0] ptr_add(input logic [1:0] base, input logic [2:0] off);
        logic [2:0] sum;
        sum = {1'b0, base} + off;
        sum = (sum >= DEPTH_C) ? (sum - DEPTH_C) : sum;
        return sum[1:0];
    endfunction

    // Handshake and buffer-pointer helpers derived from registered state.
    always_comb begin
        valid_s        = (count_q != 3'd0);
        pop_s          = valid_s & bus.inst_ready;
        tail_s         = ptr_add(head_q, count_q);
        redirect_tgt_s = bus.redirect_pc & ~64'd3;
`ifdef IFETCH_BOUND_CHECK_EN
        out_of_range_s = (pc_q > LAST_ADDR);
`else
        out_of_range_s = 1'b0;
`endif
    end

    // Next-state logic: FSM, push/flush decisions, pc/count/head update.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        head_d  = head_q;
        push_s  = 1'b0;
        flush_s = 1'b0;

        case (state_q)
            ST_START: begin
                // Redirects are ignored here; the buffer is empty so no pop.
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.redirect_valid) begin
                    flush_s = 1'b1;
                end else if (out_of_range_s) begin
                    state_d = ST_FAULT;
                end else begin
                    // A pop this cycle frees the slot the push will use.
                    push_s = (count_q < DEPTH_C) | pop_s;
                end
            end
            ST_FAULT: begin
                if (bus.redirect_valid) begin
                    flush_s = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            default: begin
                state_d = ST_START;
            end
        endcase

        if (flush_s) begin
            // Flush discards any pop this cycle along with the whole buffer.
            count_d = 3'd0;
            head_d  = 2'd0;
            pc_d    = redirect_tgt_s;
        end else begin
            count_d = count_q + {2'b00, push_s} - {2'b00, pop_s};
            head_d  = pop_s ? ptr_add(head_q, 3'd1) : head_q;
            pc_d    = push_s ? (pc_q + 64'd4) : pc_q;
        end
    end

    // Control registers: state, pc, occupancy and head pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_START;
            pc_q    <= RESET_PC;
            count_q <= 3'd0;
            head_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            head_q  <= head_d;
        end
    end

    // Buffer entry storage: capture {pc, Instruction} at the tail on push.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                ent_pc_q[i]  <= 64'd0;
                ent_ins_q[i] <= 32'd0;
            end
        end else if (push_s) begin
            ent_pc_q[tail_s]  <= pc_q;
            ent_ins_q[tail_s] <= bus.Instruction;
        end else begin
            for (int i = 0; i < 4; i++) begin
                ent_pc_q[i]  <= ent_pc_q[i];
                ent_ins_q[i] <= ent_ins_q[i];
            end
        end
    end

    // Outputs: all derived directly from registered state.
    always_comb begin
`ifdef IFETCH_BOUND_CHECK_EN
        bus.Inst_Address = pc_q;
        bus.fault        = (state_q == ST_FAULT);
`else
        bus.Inst_Address = pc_q & ADDR_MASK;
        bus.fault        = 1'b0;
`endif
        bus.inst_valid = valid_s;
        if (valid_s) begin
            bus.inst_out = ent_ins_q[head_q];
            bus.inst_pc  = ent_pc_q[head_q];
        end else begin
            bus.inst_out = 32'd0;
            bus.inst_pc  = 64'd0;
        end
    end

endmodule

// File: tb/tb_inst_fetch_controller.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_controller
//
// Directed scenarios followed by randomized ready/redirect/reset traffic.
// A queue-based reference model tracks expected buffer contents and PC.
// Compile with IFETCH_BOUND_CHECK_EN defined to exercise the range check.
// ---------------------------------------------------------------------------
module tb_inst_fetch_controller;

    localparam int unsigned MEM_BYTES = 16;
    localparam int unsigned DEPTH     = 2;
    localparam logic [63:0] RESET_PC  = 64'd0;
`ifdef IFETCH_BOUND_CHECK_EN
    localparam bit BOUND = 1'b1;
`else
    localparam bit BOUND = 1'b0;
`endif

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] ins;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    inst_fetch_controller_if bus_if ();

    inst_fetch_controller #(
        .MEM_BYTES (MEM_BYTES),
        .RESET_PC  (RESET_PC),
        .DEPTH     (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    logic [7:0] mem_b [MEM_BYTES];

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        int i;
        if (a <= 64'(MEM_BYTES - 4)) begin
            i = int'(a[31:0]);
            return {mem_b[i+3], mem_b[i+2], mem_b[i+1], mem_b[i]};
        end else begin
            return 32'd0;
        end
    endfunction

    assign bus_if.Instruction = mem_word(bus_if.Inst_Address);

    // Reference model state
    ent_t        mq[$];
    logic [63:0] m_pc;
    int          m_age;
    bit          m_halted;

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic logic [63:0] m_addr();
        return BOUND ? m_pc : (m_pc & 64'(MEM_BYTES - 1));
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pc     = RESET_PC;
        m_age    = 0;
        m_halted = 1'b0;
    endtask

    // One clock edge of the reference model.
    task automatic model_step(input bit rst, input bit rv, input logic [63:0] rpc, input bit rdy);
        bit   popped;
        ent_t e;
        if (rst) begin
            model_reset();
        end else if (m_age == 0) begin
            m_age = 1;
        end else begin
            popped = (mq.size() != 0) && rdy;
            if (rv) begin
                mq.delete();
                m_pc     = rpc & ~64'd3;
                m_halted = 1'b0;
            end else begin
                if (popped) void'(mq.pop_front());
                if (!m_halted) begin
                    if (BOUND && (m_pc > 64'(MEM_BYTES - 4))) begin
                        m_halted = 1'b1;
                    end else if (mq.size() < int'(DEPTH)) begin
                        e.pc  = m_pc;
                        e.ins = mem_word(m_addr());
                        mq.push_back(e);
                        m_pc = m_pc + 64'd4;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_model();
        bit          ev;
        logic [63:0] epc;
        logic [31:0] eins;
        ev   = (mq.size() != 0);
        epc  = ev ? mq[0].pc : 64'd0;
        eins = ev ? mq[0].ins : 32'd0;
        chk("model_valid", {63'd0, bus_if.inst_valid}, {63'd0, ev});
        chk("model_inst_out", {32'd0, bus_if.inst_out}, {32'd0, eins});
        chk("model_inst_pc", bus_if.inst_pc, epc);
        chk("model_fault", {63'd0, bus_if.fault}, {63'd0, m_halted});
        chk("model_addr", bus_if.Inst_Address, m_addr());
    endtask

    // Drive one cycle's inputs, check against the model, then clock both.
    task automatic cyc(input bit rst, input bit rv, input logic [63:0] rpc, input bit rdy);
        reset                 = rst;
        bus_if.redirect_valid = rv;
        bus_if.redirect_pc    = rpc;
        bus_if.inst_ready     = rdy;
        #1;
        compare_model();
        @(posedge clk);
        model_step(rst, rv, rpc, rdy);
        @(negedge clk);
    endtask

    task automatic head_is(input string tag, input logic [63:0] pc, input logic [31:0] ins);
        chk({tag, "_valid"}, {63'd0, bus_if.inst_valid}, 64'd1);
        chk({tag, "_pc"}, bus_if.inst_pc, pc);
        chk({tag, "_ins"}, {32'd0, bus_if.inst_out}, {32'd0, ins});
    endtask

    localparam logic [31:0] W0 = 32'h0F05_3483;
    localparam logic [31:0] W1 = 32'h009A_84B3;
    localparam logic [31:0] W2 = 32'h0014_8493;
    localparam logic [31:0] W3 = 32'h0E95_3823;

    initial begin
        logic [31:0] words [4];
        logic [31:0] w;
        bit          r_rst, r_rv, r_rdy;
        logic [63:0] r_pc;
        words[0] = W0; words[1] = W1; words[2] = W2; words[3] = W3;
        for (int k = 0; k < 4; k++) begin
            w = words[k];
            mem_b[4*k]   = w[7:0];
            mem_b[4*k+1] = w[15:8];
            mem_b[4*k+2] = w[23:16];
            mem_b[4*k+3] = w[31:24];
        end

        reset                 = 1'b1;
        bus_if.redirect_valid = 1'b0;
        bus_if.redirect_pc    = 64'd0;
        bus_if.inst_ready     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_reset();

        // Reset, then ready held high: one word per cycle from cycle 2.
        cyc(1'b1, 1'b0, 64'd0, 1'b1);
        chk("rst_valid", {63'd0, bus_if.inst_valid}, 64'd0);
        chk("rst_fault", {63'd0, bus_if.fault}, 64'd0);
        chk("rst_addr", bus_if.Inst_Address, RESET_PC);
        chk("rst_inst_pc", bus_if.inst_pc, 64'd0);
        cyc(1'b0, 1'b0, 64'd0, 1'b1);
        chk("c1_valid", {63'd0, bus_if.inst_valid}, 64'd0);
        cyc(1'b0, 1'b0, 64'd0, 1'b1);
        head_is("run_h0", 64'd0, W0);
        cyc(1'b0, 1'b0, 64'd0, 1'b1);
        head_is("run_h1", 64'd4, W1);
        cyc(1'b0, 1'b0, 64'd0, 1'b1);
        head_is("run_h2", 64'd8, W2);
        cyc(1'b0, 1'b0, 64'd0, 1'b1);
        head_is("run_h3", 64'd12, W3);

        // Stall: buffer fills with pc 0 and 4, pc holds at 8.
        cyc(1'b1, 1'b0, 64'd0, 1'b0);
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 64'd0, 1'b0);
        chk("stall_addr", bus_if.Inst_Address, 64'd8);
        head_is("stall_h0", 64'd0, W0);
        cyc(1'b0, 1'b0, 64'd0, 1'b1);
        head_is("drain_h1", 64'd4, W1);
        cyc(1'b0, 1'b0, 64'd0, 1'b1);
        head_is("drain_h2", 64'd8, W2);
        cyc(1'b0, 1'b0, 64'd0, 1'b1);
        head_is("drain_h3", 64'd12, W3);

        // Redirect to 0x9 (aligned to 8) while holding pc 0 and 4.
        cyc(1'b1, 1'b0, 64'd0, 1'b0);
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 64'd0, 1'b0);
        cyc(1'b0, 1'b1, 64'h9, 1'b0);
        chk("redir_valid", {63'd0, bus_if.inst_valid}, 64'd0);
        chk("redir_addr", bus_if.Inst_Address, 64'd8);
        cyc(1'b0, 1'b0, 64'd0, 1'b0);
        head_is("redir_h", 64'd8, W2);

        // Reset while full and stalled, then the startup repeats.
        cyc(1'b0, 1'b0, 64'd0, 1'b0);
        cyc(1'b1, 1'b0, 64'd0, 1'b0);
        chk("rstfull_valid", {63'd0, bus_if.inst_valid}, 64'd0);
        chk("rstfull_addr", bus_if.Inst_Address, RESET_PC);
        chk("rstfull_fault", {63'd0, bus_if.fault}, 64'd0);
        cyc(1'b0, 1'b0, 64'd0, 1'b1);
        cyc(1'b0, 1'b0, 64'd0, 1'b1);
        head_is("rstfull_h0", 64'd0, W0);

`ifdef IFETCH_BOUND_CHECK_EN
        // Run past the end of memory: fault, then redirect back to 4.
        cyc(1'b1, 1'b0, 64'd0, 1'b1);
        cyc(1'b0, 1'b0, 64'd0, 1'b1);
        cyc(1'b0, 1'b0, 64'd0, 1'b1);
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 64'd0, 1'b1);
        head_is("bnd_h3", 64'd12, W3);
        chk("bnd_fault_pre", {63'd0, bus_if.fault}, 64'd0);
        cyc(1'b0, 1'b0, 64'd0, 1'b1);
        chk("bnd_fault", {63'd0, bus_if.fault}, 64'd1);
        chk("bnd_novalid", {63'd0, bus_if.inst_valid}, 64'd0);
        cyc(1'b0, 1'b1, 64'd4, 1'b1);
        chk("bnd_fault_clr", {63'd0, bus_if.fault}, 64'd0);
        chk("bnd_r1_valid", {63'd0, bus_if.inst_valid}, 64'd0);
        cyc(1'b0, 1'b0, 64'd0, 1'b1);
        head_is("bnd_redir_h", 64'd4, W1);
`else
        // Fetch wraps within memory while inst_pc keeps the full pc.
        cyc(1'b1, 1'b0, 64'd0, 1'b1);
        cyc(1'b0, 1'b0, 64'd0, 1'b1);
        cyc(1'b0, 1'b0, 64'd0, 1'b1);
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 64'd0, 1'b1);
        chk("wrap_addr", bus_if.Inst_Address, 64'd0);
        cyc(1'b0, 1'b0, 64'd0, 1'b1);
        head_is("wrap_h16", 64'd16, W0);
        chk("wrap_fault", {63'd0, bus_if.fault}, 64'd0);
        // 64-bit pc wrap.
        cyc(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        cyc(1'b0, 1'b0, 64'd0, 1'b1);
        head_is("wrap64_h", 64'hFFFF_FFFF_FFFF_FFFC, W3);
        cyc(1'b0, 1'b0, 64'd0, 1'b1);
        head_is("wrap64_h0", 64'd0, W0);
`endif

        // Randomized traffic checked against the model every cycle.
        for (int k = 0; k < 600; k++) begin
            r_rst = ($urandom % 64) == 0;
            r_rv  = ($urandom % 8) == 0;
            r_rdy = ($urandom % 4) != 0;
            case ($urandom % 3)
                0:       r_pc = 64'($urandom_range(0, 31));
                1:       r_pc = {32'hFFFF_FFFF, $urandom};
                default: r_pc = {$urandom, $urandom};
            endcase
            cyc(r_rst, r_rv, r_pc, r_rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
